// File: rtl/qea_pkg.sv
// Shared FSM encoding, initial amplitude and depth helper
// for the QEA host sequencer.
package qea_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_START,
        S_RUN,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT
    } qea_state_e;

    // 1.0 + 0i in Q2.30 re:im
    localparam logic [63:0] INIT_AMP = 64'h40000000_00000000;

    function automatic logic [31:0] qea_depth(input logic [31:0] log2_depth);
        return 32'd1 << log2_depth;
    endfunction

endpackage

// File: rtl/qea_cycle_counter.sv
// Saturating execution-cycle counter with clear, enable and
// timeout compare; o_count includes the current cycle.
module qea_cycle_counter #(
    parameter int W       = 32,
    parameter int TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_timeout
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] incl;

    always_comb begin
        incl  = (&cnt_q) ? cnt_q : cnt_q + W'(1);
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = incl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count   = incl;
    assign o_timeout = (TIMEOUT != 0) && (incl >= W'(TIMEOUT));

endmodule

// File: rtl/qea_host_sequencer.sv
// Host-side sequencer: loads QEA context, initialises state RAM,
// starts and times the run, then streams the state vector out.
module qea_host_sequencer
    import qea_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int CYCLE_CNT_WIDTH         = 32,
    parameter int TIMEOUT_CYCLES          = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_timeout,
    output logic                                 o_err,
    output logic [CYCLE_CNT_WIDTH-1:0]           o_cycle_count,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);

    localparam int SW  = PE_NUM * STATE_DATA_WIDTH;
    localparam int CAW = GATE_CONTEXT_ADDR_WIDTH;
    localparam int SAW = STATE_ADDR_WIDTH;
    localparam int CW  = CYCLE_CNT_WIDTH;

    qea_state_e state_q, state_d;
    logic busy_q, busy_d, done_q, done_d;
    logic timeout_q, timeout_d, err_q, err_d;
    logic start_q, start_d, ready_q, ready_d;
    logic ctx_en_q, ctx_en_d, ctx_wea_q, ctx_wea_d;
    logic rd_valid_q, rd_valid_d, armed_q, armed_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [MAX_QBIT_WIDTH-1:0] qbit_q, qbit_d;
    logic [CAW-1:0] ctx_addr_q, ctx_addr_d;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
    logic [CAW:0] ins_q, ins_d, ctx_idx_q, ctx_idx_d;
    logic [PE_NUM-1:0] st_ena_q, st_ena_d, st_wea_q, st_wea_d;
    logic [SAW-1:0] st_addr_q, st_addr_d;
    logic [SAW-1:0] addr_q, addr_d, last_q, last_d;
    logic [SW-1:0] st_dina_q, st_dina_d, rd_data_q, rd_data_d;
    logic [31:0] shift;
    logic [CW-1:0] cnt_incl;
    logic cnt_to, cnt_clr, cnt_en;

    assign cnt_clr = state_q inside {S_IDLE, S_LOAD, S_INIT};
    assign cnt_en  = state_q inside {S_START, S_RUN};

    qea_cycle_counter #(
        .W       (CW),
        .TIMEOUT (TIMEOUT_CYCLES)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (cnt_clr),
        .i_en      (cnt_en),
        .o_count   (cnt_incl),
        .o_timeout (cnt_to)
    );

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        err_d      = err_q;
        start_d    = 1'b0;
        ctx_en_d   = 1'b0;
        ctx_wea_d  = 1'b0;
        ctx_addr_d = ctx_addr_q;
        ctx_data_d = ctx_data_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        armed_d    = armed_q;
        cycles_d   = cycles_q;
        qbit_d     = qbit_q;
        ins_d      = ins_q;
        ctx_idx_d  = ctx_idx_q;
        st_ena_d   = '0;
        st_wea_d   = '0;
        st_addr_d  = st_addr_q;
        st_dina_d  = st_dina_q;
        addr_d     = addr_q;
        last_d     = last_q;
        shift      = 32'(i_qbit_num) - 32'(PE_NUM_WIDTH);
        unique case (state_q)
            S_IDLE: begin
                // the cycle showing o_done must not relaunch
                if (i_run && !done_q) begin
                    if (32'(i_qbit_num) < 32'(PE_NUM_WIDTH) || shift > 32'(SAW)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d     = 1'b0;
                        timeout_d = 1'b0;
                        qbit_d    = i_qbit_num;
                        ins_d     = i_ins_num;
                        ctx_idx_d = '0;
                        addr_d    = '0;
                        last_d    = SAW'(qea_depth(shift) - 32'd1);
                        state_d   = (i_ins_num == '0) ? S_INIT : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (i_ctx_valid && ready_q) begin
                    ctx_en_d   = 1'b1;
                    ctx_wea_d  = 1'b1;
                    ctx_addr_d = ctx_idx_q[CAW-1:0];
                    ctx_data_d = i_ctx_data;
                    ctx_idx_d  = ctx_idx_q + (CAW+1)'(1);
                    if (ctx_idx_d == ins_q) state_d = S_INIT;
                end
            end
            S_INIT: begin
                st_ena_d  = '1;
                st_wea_d  = '1;
                st_addr_d = addr_q;
                st_dina_d = '0;
                if (addr_q == '0) begin
                    st_dina_d[SW-1 -: STATE_DATA_WIDTH] = STATE_DATA_WIDTH'(INIT_AMP);
                end
                if (addr_q == last_q) begin
                    addr_d  = '0;
                    state_d = S_START;
                end else begin
                    addr_d = addr_q + SAW'(1);
                end
            end
            S_START: begin
                start_d = 1'b1;
                armed_d = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // first RUN cycle may still see the previous run's complete
                armed_d = 1'b1;
                if (armed_q && i_qea_complete) begin
                    cycles_d = cnt_incl;
                    state_d  = S_RD_ISSUE;
                end else if (cnt_to) begin
                    cycles_d  = cnt_incl;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                rd_valid_d = 1'b1;
                rd_data_d  = i_qea_state_dout;
                state_d    = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (i_rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (addr_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + SAW'(1);
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_RD_ISSUE) begin
            st_ena_d  = '1;
            st_wea_d  = '0;
            st_addr_d = addr_d;
        end
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            ready_q    <= 1'b0;
            ctx_en_q   <= 1'b0;
            ctx_wea_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            armed_q    <= 1'b0;
            cycles_q   <= '0;
            qbit_q     <= '0;
            ctx_addr_q <= '0;
            ctx_data_q <= '0;
            ins_q      <= '0;
            ctx_idx_q  <= '0;
            st_ena_q   <= '0;
            st_wea_q   <= '0;
            st_addr_q  <= '0;
            st_dina_q  <= '0;
            rd_data_q  <= '0;
            addr_q     <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
            start_q    <= start_d;
            ready_q    <= ready_d;
            ctx_en_q   <= ctx_en_d;
            ctx_wea_q  <= ctx_wea_d;
            rd_valid_q <= rd_valid_d;
            armed_q    <= armed_d;
            cycles_q   <= cycles_d;
            qbit_q     <= qbit_d;
            ctx_addr_q <= ctx_addr_d;
            ctx_data_q <= ctx_data_d;
            ins_q      <= ins_d;
            ctx_idx_q  <= ctx_idx_d;
            st_ena_q   <= st_ena_d;
            st_wea_q   <= st_wea_d;
            st_addr_q  <= st_addr_d;
            st_dina_q  <= st_dina_d;
            rd_data_q  <= rd_data_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_err         = err_q;
    assign o_cycle_count = cycles_q;
    assign o_qea_start   = start_q;
    assign o_qbit_num    = qbit_q;
    assign o_ctx_ready   = ready_q;
    assign o_ctx_en      = ctx_en_q;
    assign o_ctx_wea     = ctx_wea_q;
    assign o_ctx_addr    = ctx_addr_q;
    assign o_ctx_data    = ctx_data_q;
    assign o_state_ena   = st_ena_q;
    assign o_state_wea   = st_wea_q;
    assign o_state_addra = st_addr_q;
    assign o_state_dina  = st_dina_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = rd_data_q;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer with behavioural
// context RAM, state RAM and QEA completion models.
module tb_qea_host_sequencer;

    logic clk, rst_n;
    logic i_run, i_ctx_valid, o_ctx_ready, o_rd_valid, i_rd_ready;
    logic [5:0] i_qbit_num, o_qbit_num;
    logic [16:0] i_ins_num;
    logic [63:0] i_ctx_data, o_ctx_data;
    logic [255:0] o_rd_data, o_state_dina, i_qea_state_dout;
    logic o_busy, o_done, o_timeout, o_err, o_qea_start;
    logic [31:0] o_cycle_count;
    logic o_ctx_en, o_ctx_wea, i_qea_complete;
    logic [15:0] o_ctx_addr, o_state_addra;
    logic [3:0] o_state_ena, o_state_wea;

    qea_host_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run),
        .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready),
        .i_ctx_data(i_ctx_data), .o_rd_valid(o_rd_valid),
        .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
        .o_err(o_err), .o_cycle_count(o_cycle_count),
        .o_qea_start(o_qea_start), .o_qbit_num(o_qbit_num),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
        .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
        .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
        .i_qea_complete(i_qea_complete),
        .i_qea_state_dout(i_qea_state_dout)
    );

    localparam logic [255:0] INITW = {64'h40000000_00000000, 192'd0};

    int tests = 0;
    int fails = 0;

    function automatic logic [63:0] ctxw(input int k);
        return {32'hC0DE0000 ^ 32'(k), 32'(k) * 32'h9E3779B1};
    endfunction

    function automatic logic [255:0] rbw(input int k);
        return {4{32'hBEEF0000 + 32'(k), 32'(k) * 32'h01010101}};
    endfunction

    // Behavioural QEA: RAMs plus completion after qea_n cycles
    logic [255:0] smem [0:1023];
    logic [255:0] sdout;
    logic complete, clr_req, qea_never;
    int qea_n, cd, ctx_wr, ctx_bad, st_wr, starts, init_bad, ib, cur_depth;

    assign i_qea_complete   = complete;
    assign i_qea_state_dout = sdout;

    always @(posedge clk) begin
        if (clr_req) begin
            ctx_wr <= 0; ctx_bad <= 0; st_wr <= 0; starts <= 0;
            for (int a = 0; a < 1024; a++) smem[a] <= {8{32'hDEADBEEF}};
        end else begin
            if (o_ctx_en && o_ctx_wea) begin
                if (o_ctx_addr !== 16'(ctx_wr) || o_ctx_data !== ctxw(ctx_wr))
                    ctx_bad <= ctx_bad + 1;
                ctx_wr <= ctx_wr + 1;
            end
            if (o_state_ena == 4'hF && o_state_wea == 4'hF) begin
                smem[o_state_addra[9:0]] <= o_state_dina;
                st_wr <= st_wr + 1;
            end else if (o_state_ena == 4'hF) begin
                sdout <= smem[o_state_addra[9:0]];
            end
            if (o_qea_start) begin
                ib = 0;
                for (int a = 0; a < cur_depth; a++)
                    if (smem[a] !== (a == 0 ? INITW : 256'd0)) ib++;
                init_bad <= ib;
                starts <= starts + 1;
                complete <= 1'b0;
                cd <= qea_never ? 0 : qea_n;
            end else if (cd != 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    complete <= 1'b1;
                    for (int a = 0; a < 1024; a++) smem[a] <= rbw(a);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_strobes", 256'({o_busy, o_done, o_timeout, o_err, o_qea_start,
            o_ctx_ready, o_ctx_en, o_ctx_wea, o_rd_valid,
            o_state_ena, o_state_wea}), 0);
        chk("rst_regs", 256'({o_cycle_count, o_qbit_num, o_ctx_addr,
            o_state_addra}), 0);
        chk("rst_data", 256'({|o_rd_data, |o_ctx_data, |o_state_dina}), 0);
    endtask

    task automatic clr_stats(input int depth);
        cur_depth = depth;
        clr_req = 1;
        @(negedge clk);
        clr_req = 0;
    endtask

    task automatic do_run(input int qb, input int ins, input int n,
                          input bit never, input int stall_word,
                          input int exp_cyc);
        int depth, k, cyc, hold, rd_bad, stab_bad;
        bit hs;
        depth = 1 << (qb - 2);
        qea_n = n;
        qea_never = never;
        clr_stats(depth);
        i_qbit_num = 6'(qb);
        i_ins_num = 17'(ins);
        i_run = 1;
        @(negedge clk);
        i_run = 0;
        chk("busy_after_run", 256'(o_busy), 1);
        chk("flags_cleared", 256'({o_err, o_timeout}), 0);
        chk("qbit_out", 256'(o_qbit_num), 256'(qb));
        k = 0;
        cyc = 0;
        while (k < ins && cyc < 4 * ins + 10) begin
            i_ctx_valid = cyc[0];
            i_ctx_data = ctxw(k);
            hs = i_ctx_valid && o_ctx_ready;
            @(negedge clk);
            cyc++;
            if (hs) k++;
        end
        i_ctx_valid = 0;
        chk("ctx_handshakes", 256'(k), 256'(ins));
        cyc = 0;
        while (!o_rd_valid && o_busy && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("ctx_writes", 256'(ctx_wr), 256'(ins));
        chk("ctx_order_data", 256'(ctx_bad), 0);
        chk("init_writes", 256'(st_wr), 256'(depth));
        chk("init_data", 256'(init_bad), 0);
        chk("start_pulses", 256'(starts), 1);
        if (never) begin
            chk("timeout_flag", 256'(o_timeout), 1);
            chk("timeout_busy", 256'(o_busy), 0);
            chk("timeout_count", 256'(o_cycle_count), 256'(exp_cyc));
            chk("timeout_no_rd", 256'(o_rd_valid), 0);
        end else begin
            chk("rd_reached", 256'(o_rd_valid), 1);
            chk("cycle_count", 256'(o_cycle_count), 256'(exp_cyc));
            k = 0; cyc = 0; hold = 0; rd_bad = 0; stab_bad = 0;
            while (k < depth && cyc < 20000) begin
                if (o_rd_valid) begin
                    if (k == stall_word && hold < 10) begin
                        i_rd_ready = 0;
                        if (o_rd_data !== rbw(k)) stab_bad++;
                        if (o_state_addra !== 16'(k)) stab_bad++;
                        hold++;
                    end else begin
                        i_rd_ready = 1;
                        if (o_rd_data !== rbw(k)) rd_bad++;
                        k++;
                    end
                end else begin
                    i_rd_ready = 0;
                end
                @(negedge clk);
                cyc++;
            end
            i_rd_ready = 0;
            chk("rd_words", 256'(k), 256'(depth));
            chk("rd_data", 256'(rd_bad), 0);
            if (stall_word >= 0) chk("rd_stall_stable", 256'(stab_bad), 0);
            chk("done_pulse", 256'(o_done), 1);
            i_qbit_num = 6'd4;
            i_ins_num = 17'd0;
            i_run = 1;
            @(negedge clk);
            i_run = 0;
            chk("run_on_done_ignored", 256'(o_busy), 0);
            chk("done_one_cycle", 256'(o_done), 0);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 0; i_run = 0; i_qbit_num = 0; i_ins_num = 0;
        i_ctx_valid = 0; i_ctx_data = 0; i_rd_ready = 0;
        clr_req = 0; qea_n = 0; qea_never = 0; cur_depth = 0;
        complete = 0; cd = 0; sdout = 0; init_bad = 0; ib = 0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1;
        @(negedge clk);

        // qbit 8 -> depth 64, 20 ctx words, complete N=50 -> 53 cycles
        do_run(8, 20, 50, 0, 3, 53);
        // stale complete from the previous run must be ignored: 20 -> 23
        do_run(4, 0, 20, 0, -1, 23);
        // complete never comes: timeout at 100
        do_run(5, 2, 0, 1, -1, 100);

        clr_stats(0);
        i_qbit_num = 6'd1; i_run = 1;
        @(negedge clk);
        i_run = 0;
        chk("err_low_qbit", 256'(o_err), 1);
        chk("err_not_busy", 256'(o_busy), 0);
        i_qbit_num = 6'd19; i_run = 1;
        @(negedge clk);
        i_run = 0;
        chk("err_high_qbit", 256'(o_err), 1);
        repeat (3) @(negedge clk);
        chk("err_no_start", 256'(starts), 0);

        do_run(4, 3, 20, 0, -1, 23);

        i_qbit_num = 6'd8; i_ins_num = 17'd0; i_run = 1;
        @(negedge clk);
        i_run = 0;
        repeat (5) @(negedge clk);
        chk("init_writing", 256'({o_state_ena, o_state_wea}), 256'(8'hFF));
        rst_n = 0;
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_run(4, 3, 20, 0, -1, 23);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
